// File: rtl/pi_loop_filter_gear.sv
// PI loop filter for the symbol-timing loop with saturating integrator and a lock-detect gear shift.
// Define LF_ROUND_EN for round-half-away-from-zero gain shifts; otherwise they are plain arithmetic shifts.
module pi_loop_filter_gear #(
  parameter int unsigned WERR          = 18,
  parameter int unsigned ACC_WIDTH     = 24,
  parameter int unsigned LOCK_WIN_LOG2 = 6,
  parameter int unsigned LOCK_CNT      = 4,
  parameter int unsigned UNLOCK_CNT    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [WERR-1:0] e_in_i,
  input  logic            e_valid_i,
  input  logic [4:0]      kp_acq_sh_i,
  input  logic [4:0]      ki_acq_sh_i,
  input  logic [4:0]      kp_trk_sh_i,
  input  logic [4:0]      ki_trk_sh_i,
  input  logic [WERR-1:0] lock_thresh_i,
  input  logic            freeze_i,
  input  logic            clear_i,
  output logic [WERR-1:0] ctrl_o,
  output logic            ctrl_val_o,
  output logic            locked_o,
  output logic            acc_sat_o
);

  localparam int unsigned SUMW   = WERR + LOCK_WIN_LOG2;
  localparam int unsigned CNTMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int unsigned CNTW   = $clog2(CNTMAX + 1);
  localparam int unsigned PADW   = ACC_WIDTH - WERR + 2;

  localparam logic [4:0]                SH_MAX   = 5'(WERR - 1);
  localparam logic [WERR-1:0]           E_MIN    = {1'b1, {(WERR-1){1'b0}}};
  localparam logic [WERR-1:0]           E_MAXU   = {1'b0, {(WERR-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MAX  = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MIN  = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] CTRL_MAX = {{PADW{1'b0}}, {(WERR-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] CTRL_MIN = {{PADW{1'b1}}, {(WERR-1){1'b0}}};

  typedef enum logic {S_ACQ = 1'b0, S_TRACK = 1'b1} state_t;

  state_t                       r_state, w_state_nxt;
  logic [CNTW-1:0]              r_pass_cnt, r_fail_cnt, w_pass_nxt, w_fail_nxt;
  logic                         r_locked;
  logic signed [WERR-1:0]       r_p_term, r_i_term;
  logic                         r_s1_val;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_acc_sat;
  logic [WERR-1:0]              r_ctrl;
  logic                         r_ctrl_val;
  logic [SUMW-1:0]              r_win_sum;
  logic [LOCK_WIN_LOG2-1:0]     r_win_cnt;

  logic                         w_take;
  logic signed [WERR-1:0]       w_e;
  logic [4:0]                   w_kp_sel, w_ki_sel, w_kp_sh, w_ki_sh;
  logic signed [ACC_WIDTH:0]    w_acc_sum, w_ctrl_sum;
  logic                         w_acc_ovf;
  logic signed [ACC_WIDTH-1:0]  w_acc_clamp, w_acc_base;
  logic [WERR-1:0]              w_ctrl_sat;
  logic [WERR-1:0]              w_abs_e;
  logic [SUMW-1:0]              w_win_tot;
  logic                         w_win_end, w_win_pass;

  // Gain shift: e * 2^-sh, either rounded half away from zero or floored.
  function automatic logic signed [WERR-1:0] f_scale(input logic signed [WERR-1:0] e,
                                                     input logic [4:0] sh);
`ifdef LF_ROUND_EN
    logic [WERR:0] mag;
    logic [WERR:0] rnd;
    if (sh == 5'd0) return e;
    mag = e[WERR-1] ? ((WERR+1)'(0) - {e[WERR-1], e}) : {1'b0, e};
    rnd = (mag + ((WERR+1)'(1) << (sh - 5'd1))) >> sh;
    return e[WERR-1] ? $signed(WERR'((WERR+1)'(0) - rnd)) : $signed(WERR'(rnd));
`else
    return e >>> sh;
`endif
  endfunction

  assign w_take   = e_valid_i & ~clear_i;
  assign w_e      = $signed(e_in_i);
  assign w_kp_sel = (r_state == S_TRACK) ? kp_trk_sh_i : kp_acq_sh_i;
  assign w_ki_sel = (r_state == S_TRACK) ? ki_trk_sh_i : ki_acq_sh_i;
  assign w_kp_sh  = (w_kp_sel > SH_MAX) ? SH_MAX : w_kp_sel;
  assign w_ki_sh  = (w_ki_sel > SH_MAX) ? SH_MAX : w_ki_sel;

  // Integrator update with clamp; the held value feeds ctrl while frozen.
  assign w_acc_sum   = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(r_i_term);
  assign w_acc_ovf   = w_acc_sum[ACC_WIDTH] ^ w_acc_sum[ACC_WIDTH-1];
  assign w_acc_clamp = w_acc_ovf ? ACC_WIDTH'(w_acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                 : ACC_WIDTH'(w_acc_sum);
  assign w_acc_base  = freeze_i ? r_acc : w_acc_clamp;
  assign w_ctrl_sum  = (ACC_WIDTH+1)'(w_acc_base) + (ACC_WIDTH+1)'(r_p_term);
  assign w_ctrl_sat  = (w_ctrl_sum > CTRL_MAX) ? WERR'(CTRL_MAX) :
                       (w_ctrl_sum < CTRL_MIN) ? WERR'(CTRL_MIN) : WERR'(w_ctrl_sum);

  // Lock window: |e| with the most negative code folded onto the positive maximum.
  assign w_abs_e    = w_e[WERR-1] ? ((e_in_i == E_MIN) ? E_MAXU : WERR'(-w_e)) : WERR'(w_e);
  assign w_win_tot  = r_win_sum + SUMW'(w_abs_e);
  assign w_win_end  = w_take & (&r_win_cnt);
  assign w_win_pass = (w_win_tot >> LOCK_WIN_LOG2) <= SUMW'(lock_thresh_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_ACQ;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (clear_i) begin
      r_state    <= S_ACQ;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pass_cnt <= w_pass_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_locked   <= (w_state_nxt == S_TRACK);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass_cnt;
    w_fail_nxt  = r_fail_cnt;
    if (w_win_end) begin
      case (r_state)
        S_ACQ: begin
          if (!w_win_pass) begin
            w_pass_nxt = '0;
          end else if (r_pass_cnt + CNTW'(1) == CNTW'(LOCK_CNT)) begin
            w_state_nxt = S_TRACK;
            w_pass_nxt  = '0;
            w_fail_nxt  = '0;
          end else begin
            w_pass_nxt = r_pass_cnt + CNTW'(1);
          end
        end
        S_TRACK: begin
          if (w_win_pass) begin
            w_fail_nxt = '0;
          end else if (r_fail_cnt + CNTW'(1) == CNTW'(UNLOCK_CNT)) begin
            w_state_nxt = S_ACQ;
            w_pass_nxt  = '0;
            w_fail_nxt  = '0;
          end else begin
            w_fail_nxt = r_fail_cnt + CNTW'(1);
          end
        end
        default: w_state_nxt = S_ACQ;
      endcase
    end
  end

  // Two-stage datapath plus lock-window accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p_term   <= '0;
      r_i_term   <= '0;
      r_s1_val   <= 1'b0;
      r_acc      <= '0;
      r_acc_sat  <= 1'b0;
      r_ctrl     <= '0;
      r_ctrl_val <= 1'b0;
      r_win_sum  <= '0;
      r_win_cnt  <= '0;
    end else if (clear_i) begin
      r_p_term   <= '0;
      r_i_term   <= '0;
      r_s1_val   <= 1'b0;
      r_acc      <= '0;
      r_acc_sat  <= 1'b0;
      r_ctrl     <= '0;
      r_ctrl_val <= 1'b0;
      r_win_sum  <= '0;
      r_win_cnt  <= '0;
    end else begin
      r_s1_val   <= w_take;
      r_ctrl_val <= r_s1_val;
      if (w_take) begin
        r_p_term  <= f_scale(w_e, w_kp_sh);
        r_i_term  <= f_scale(w_e, w_ki_sh);
        r_win_sum <= w_win_end ? '0 : w_win_tot;
        r_win_cnt <= r_win_cnt + LOCK_WIN_LOG2'(1);
      end
      if (r_s1_val) begin
        r_ctrl <= w_ctrl_sat;
        if (!freeze_i) begin
          r_acc     <= w_acc_clamp;
          r_acc_sat <= w_acc_ovf;
        end
      end
    end
  end

  assign ctrl_o     = r_ctrl;
  assign ctrl_val_o = r_ctrl_val;
  assign locked_o   = r_locked;
  assign acc_sat_o  = r_acc_sat;

endmodule

// File: tb/tb_pi_loop_filter_gear.sv
// Randomized self-checking bench for pi_loop_filter_gear against an integer reference model.
module tb_pi_loop_filter_gear;

  localparam int WERR  = 18;
  localparam int ACC_W = 20;
  localparam int LWL   = 6;
  localparam int WIN   = 1 << LWL;
  localparam int LCK   = 4;
  localparam int ULK   = 2;
`ifdef LF_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic            clk, reset_n;
  logic [WERR-1:0] e_in_i, lock_thresh_i, ctrl_o;
  logic            e_valid_i, freeze_i, clear_i;
  logic [4:0]      kp_acq_sh_i, ki_acq_sh_i, kp_trk_sh_i, ki_trk_sh_i;
  logic            ctrl_val_o, locked_o, acc_sat_o;

  int n_checks = 0;
  int n_fail   = 0;

  pi_loop_filter_gear #(
    .WERR(WERR), .ACC_WIDTH(ACC_W), .LOCK_WIN_LOG2(LWL), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .e_in_i(e_in_i), .e_valid_i(e_valid_i),
    .kp_acq_sh_i(kp_acq_sh_i), .ki_acq_sh_i(ki_acq_sh_i),
    .kp_trk_sh_i(kp_trk_sh_i), .ki_trk_sh_i(ki_trk_sh_i),
    .lock_thresh_i(lock_thresh_i), .freeze_i(freeze_i), .clear_i(clear_i),
    .ctrl_o(ctrl_o), .ctrl_val_o(ctrl_val_o), .locked_o(locked_o), .acc_sat_o(acc_sat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the filter's rules.
  longint m_acc = 0, m_ctrl = 0, m_pend_p = 0, m_pend_i = 0, m_win = 0;
  int     m_wcnt = 0, m_pass = 0, m_fail = 0;
  bit     m_pend_v = 0, m_val = 0, m_sat = 0, m_locked = 0;
  longint t_sum, t_clamp, t_base, t_e, t_abs;
  int     t_kp, t_ki;
  bit     t_pass;

  function automatic longint sat_to(input longint x, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  function automatic longint m_scale(input longint e, input int sh);
    longint mag;
    if (!RND) return e >>> sh;
    if (sh == 0) return e;
    mag = (e < 0) ? -e : e;
    mag = (mag + (64'sd1 <<< (sh - 1))) / (64'sd1 <<< sh);
    return (e < 0) ? -mag : mag;
  endfunction

  task automatic m_reset();
    m_acc = 0; m_ctrl = 0; m_pend_p = 0; m_pend_i = 0; m_win = 0;
    m_wcnt = 0; m_pass = 0; m_fail = 0;
    m_pend_v = 0; m_val = 0; m_sat = 0; m_locked = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear_i) begin
      m_reset();
    end else begin
      m_val = m_pend_v;
      if (m_pend_v) begin
        t_sum   = m_acc + m_pend_i;
        t_clamp = sat_to(t_sum, ACC_W);
        t_base  = freeze_i ? m_acc : t_clamp;
        if (!freeze_i) begin
          m_acc = t_clamp;
          m_sat = (t_clamp != t_sum);
        end
        m_ctrl = sat_to(t_base + m_pend_p, WERR);
      end
      m_pend_v = e_valid_i;
      if (e_valid_i) begin
        t_e  = longint'($signed(e_in_i));
        t_kp = m_locked ? int'(kp_trk_sh_i) : int'(kp_acq_sh_i);
        t_ki = m_locked ? int'(ki_trk_sh_i) : int'(ki_acq_sh_i);
        if (t_kp > WERR - 1) t_kp = WERR - 1;
        if (t_ki > WERR - 1) t_ki = WERR - 1;
        m_pend_p = m_scale(t_e, t_kp);
        m_pend_i = m_scale(t_e, t_ki);
        t_abs = (t_e < 0) ? -t_e : t_e;
        if (t_abs > (64'sd1 <<< (WERR - 1)) - 1) t_abs = (64'sd1 <<< (WERR - 1)) - 1;
        m_win += t_abs;
        m_wcnt++;
        if (m_wcnt == WIN) begin
          t_pass = (m_win / WIN) <= longint'(lock_thresh_i);
          m_win = 0;
          m_wcnt = 0;
          if (!m_locked) begin
            if (t_pass) m_pass++; else m_pass = 0;
            if (m_pass == LCK) begin m_locked = 1; m_pass = 0; m_fail = 0; end
          end else begin
            if (!t_pass) m_fail++; else m_fail = 0;
            if (m_fail == ULK) begin m_locked = 0; m_pass = 0; m_fail = 0; end
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("ctrl_val_o", longint'(ctrl_val_o), longint'(m_val));
    chk("ctrl_o", longint'($signed(ctrl_o)), m_ctrl);
    chk("locked_o", longint'(locked_o), longint'(m_locked));
    chk("acc_sat_o", longint'(acc_sat_o), longint'(m_sat));
  end

  task automatic strobe(input int e);
    e_in_i    = WERR'(e);
    e_valid_i = 1'b1;
    @(negedge clk);
    e_valid_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  function automatic int rsign(input int m);
    return ($urandom_range(0, 1) != 0) ? m : -m;
  endfunction

  initial begin
    clk = 1'b0; reset_n = 1'b0;
    e_in_i = '0; e_valid_i = 1'b0; freeze_i = 1'b0; clear_i = 1'b0;
    kp_acq_sh_i = 5'd7; ki_acq_sh_i = 5'd12; kp_trk_sh_i = 5'd6; ki_trk_sh_i = 5'd12;
    lock_thresh_i = WERR'(100);
    repeat (3) @(negedge clk);
    chk("reset ctrl_o", longint'(ctrl_o), 0);
    chk("reset ctrl_val_o", longint'(ctrl_val_o), 0);
    chk("reset locked_o", longint'(locked_o), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic latency and rounding pins.
    strobe(1000);
    @(negedge clk);
    chk("lat2 ctrl_val_o", longint'(ctrl_val_o), 1);
    chk("e=1000 ctrl_o", longint'($signed(ctrl_o)), RND ? 8 : 7);
    @(negedge clk);
    chk("pulse width", longint'(ctrl_val_o), 0);
    strobe(-1000);
    @(negedge clk);
    chk("e=-1000 ctrl_o", longint'($signed(ctrl_o)), RND ? -8 : -9);

    // Integration, freeze, clear-with-strobe.
    pulse_clear();
    kp_acq_sh_i = 5'd31; ki_acq_sh_i = 5'd10;
    repeat (100) strobe(2048);
    @(negedge clk);
    chk("integrate 100", longint'($signed(ctrl_o)), 200);
    freeze_i = 1'b1;
    repeat (10) strobe(2048);
    @(negedge clk); @(negedge clk);
    chk("freeze hold", longint'($signed(ctrl_o)), 200);
    freeze_i = 1'b0;
    clear_i = 1'b1; e_valid_i = 1'b1; e_in_i = WERR'(2048);
    @(negedge clk);
    clear_i = 1'b0; e_valid_i = 1'b0;
    chk("clear ctrl_o", longint'($signed(ctrl_o)), 0);
    @(negedge clk);
    chk("clear no val", longint'(ctrl_val_o), 0);
    @(negedge clk);
    chk("clear no val2", longint'(ctrl_val_o), 0);

    // Integrator clamp.
    pulse_clear();
    kp_acq_sh_i = 5'd17; ki_acq_sh_i = 5'd0;
    repeat (4) strobe(131071);
    @(negedge clk);
    chk("pre-clamp sat", longint'(acc_sat_o), 0);
    strobe(131071);
    @(negedge clk);
    chk("clamp sat", longint'(acc_sat_o), 1);
    chk("clamp ctrl", longint'($signed(ctrl_o)), 131071);
    strobe(-131072);
    @(negedge clk);
    chk("sat release", longint'(acc_sat_o), 0);

    // Lock acquire then loss.
    pulse_clear();
    kp_acq_sh_i = 5'd3; ki_acq_sh_i = 5'd8; kp_trk_sh_i = 5'd6; ki_trk_sh_i = 5'd12;
    lock_thresh_i = WERR'(100);
    for (int i = 0; i < 4 * WIN - 1; i++) strobe(rsign(50));
    chk("not yet locked", longint'(locked_o), 0);
    strobe(rsign(50));
    chk("locked after 256", longint'(locked_o), 1);
    for (int i = 0; i < 2 * WIN - 1; i++) strobe(rsign(500));
    chk("still locked", longint'(locked_o), 1);
    strobe(rsign(500));
    chk("unlocked after 128", longint'(locked_o), 0);

    // Pass/fail/pass/pass/pass/pass windows.
    pulse_clear();
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < WIN; i++) strobe(rsign((w == 1) ? 500 : 50));
      chk("alt window lock", longint'(locked_o), (w == 5) ? 1 : 0);
    end

    // Randomized traffic: small errors (lock likely), then full range.
    pulse_clear();
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 2500; c++) begin
        e_valid_i   = ($urandom_range(0, 9) < 7);
        e_in_i      = (ph == 0) ? WERR'(rsign(int'($urandom_range(0, 90))))
                                : WERR'(int'($urandom_range(0, 262143)) - 131072);
        freeze_i    = ($urandom_range(0, 9) == 0);
        clear_i     = (ph == 1) && ($urandom_range(0, 99) == 0);
        kp_acq_sh_i = 5'($urandom_range(0, 31));
        ki_acq_sh_i = 5'($urandom_range(0, 31));
        kp_trk_sh_i = 5'($urandom_range(0, 31));
        ki_trk_sh_i = 5'($urandom_range(0, 31));
        lock_thresh_i = (ph == 0) ? WERR'(60) : WERR'($urandom_range(0, 131071));
        @(negedge clk);
      end
    end
    e_valid_i = 1'b0; freeze_i = 1'b0; clear_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset with a result in flight.
    pulse_clear();
    kp_acq_sh_i = 5'd0; ki_acq_sh_i = 5'd17;
    strobe(5000);
    @(negedge clk);
    chk("pre-reset ctrl", longint'($signed(ctrl_o)), 5000);
    e_in_i = WERR'(5000); e_valid_i = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0; e_valid_i = 1'b0;
    #1;
    chk("async rst ctrl_o", longint'(ctrl_o), 0);
    chk("async rst val", longint'(ctrl_val_o), 0);
    chk("async rst locked", longint'(locked_o), 0);
    chk("async rst sat", longint'(acc_sat_o), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no val after rst", longint'(ctrl_val_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
